// File: rtl/eth_downsize_pkg.sv
// Shared definitions for the Ethernet AXI-Stream downsizer.
// The holding-register struct is sized for the widest supported input (MAX_IN_W).
// Narrower builds zero-extend into it.
package eth_downsize_pkg;

  localparam int MAX_IN_W     = 512;
  localparam int MAX_KEEP_W   = MAX_IN_W / 8;
  localparam int WORD_GRAIN_W = 64;

  // Number of bytes carried by one output word.
  function automatic int bytes_per_word(input int out_w);
    return out_w / 8;
  endfunction

  // Index of the highest output word that carries at least one enabled byte.
  // An all-zero keep maps to word 0, so a tlast beat always emits one word.
  function automatic int last_word_idx(input logic [MAX_KEEP_W-1:0] keep,
                                       input int r,
                                       input int bpw);
    int fin;
    fin = 0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if ((i < r * bpw) && keep[i]) begin
        fin = i / bpw;
      end
    end
    return fin;
  endfunction

  typedef struct packed {
    logic [MAX_IN_W-1:0]   data;
    logic [MAX_KEEP_W-1:0] keep;
    logic                  last;
  } hold_t;

endpackage

// File: rtl/eth_axis_downsizer.sv
// Wide-to-narrow AXI-Stream downsizer for the Ethernet ingress path.
// Each held input beat is emitted as R = IN_W/OUT_W words. Trailing empty
// words of a tlast beat are dropped.
// Optional feature macro: ETH_DOWNSIZE_ERR_CNT_EN. When it is defined,
// err_count counts accepted protocol-violating beats. Otherwise err_count is 0.
// IN_W must not exceed eth_downsize_pkg::MAX_IN_W.
module eth_axis_downsizer
  import eth_downsize_pkg::*;
#(
  parameter int IN_W  = 512,
  parameter int OUT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_W-1:0]      i_tdata,
  input  logic [IN_W/8-1:0]    i_tkeep,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [OUT_W-1:0]     o_tdata,
  output logic [OUT_W/8-1:0]   o_tkeep,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [15:0]          err_count
);

  localparam int R        = IN_W / OUT_W;
  localparam int BPW      = bytes_per_word(OUT_W);
  localparam int IDX_W    = (R > 1) ? $clog2(R) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(R - 1);

  hold_t            hold_q, hold_d;
  logic             held_q, held_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] fin;
  logic             at_fin;
  logic             out_fire;
  logic             in_fire;

  // Final word index of the held beat and the handshake qualifiers.
  always_comb begin
    fin      = hold_q.last ? IDX_W'(last_word_idx(hold_q.keep, R, BPW)) : IDX_LAST;
    at_fin   = (idx_q == fin);
    out_fire = held_q && o_tready;
    in_fire  = i_tvalid && i_tready;
  end

  // Stream outputs. The input side reopens in the same cycle the final word leaves.
  always_comb begin
    i_tready = !held_q || (out_fire && at_fin);
    o_tvalid = held_q;
    o_tlast  = held_q && hold_q.last && at_fin;
    o_tdata  = hold_q.data[idx_q*OUT_W +: OUT_W];
    o_tkeep  = hold_q.keep[idx_q*BPW +: BPW];
  end

  // Next-state for the word index and the holding register.
  always_comb begin
    hold_d = hold_q;
    held_d = held_q;
    idx_d  = idx_q;
    if (out_fire) begin
      if (at_fin) begin
        idx_d  = '0;
        held_d = 1'b0;
      end else begin
        idx_d  = idx_q + 1'b1;
      end
    end
    if (in_fire) begin
      hold_d.data = MAX_IN_W'(i_tdata);
      hold_d.keep = MAX_KEEP_W'(i_tkeep);
      hold_d.last = i_tlast;
      held_d      = 1'b1;
    end
  end

  // Holding register and word index, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      held_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      hold_q <= hold_d;
      held_q <= held_d;
      idx_q  <= idx_d;
    end
  end

`ifdef ETH_DOWNSIZE_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;
  logic        beat_err;

  // Flag accepted beats with an illegal keep pattern and count them, saturating.
  always_comb begin
    beat_err    = i_tlast ? (i_tkeep == '0) : (i_tkeep != '1);
    err_count_d = err_count_q;
    if (in_fire && beat_err && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // Error counter register. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_eth_axis_downsizer.sv
// Self-checking bench for eth_axis_downsizer (IN_W=512, OUT_W=64).
// The reference model expands each accepted beat into its expected words
// using byte counts.
module tb_eth_axis_downsizer;

  localparam int IN_W  = 512;
  localparam int OUT_W = 64;
  localparam int R     = IN_W / OUT_W;
  localparam int KB    = IN_W / 8;
  localparam int BPW   = OUT_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IN_W-1:0]   i_tdata = '0;
  logic [KB-1:0]     i_tkeep = '0;
  logic              i_tlast = 1'b0;
  logic              i_tvalid = 1'b0;
  logic              i_tready;
  logic [OUT_W-1:0]  o_tdata;
  logic [BPW-1:0]    o_tkeep;
  logic              o_tlast;
  logic              o_tvalid;
  logic              o_tready = 1'b0;
  logic [15:0]       err_count;

  always #5 clk = ~clk;

  eth_axis_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tdata   (i_tdata),
    .i_tkeep   (i_tkeep),
    .i_tlast   (i_tlast),
    .i_tvalid  (i_tvalid),
    .i_tready  (i_tready),
    .o_tdata   (o_tdata),
    .o_tkeep   (o_tkeep),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .err_count (err_count)
  );

  typedef struct {
    logic [IN_W-1:0] data;
    logic [KB-1:0]   keep;
    logic            last;
  } beat_t;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [BPW-1:0]   keep;
    logic             last;
  } word_t;

  beat_t src[$];
  word_t expq[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    exp_err = 0;
  int    ready_pct = 100;
  int    valid_pct = 100;
  int    words_out = 0;
  logic  stalled = 1'b0;
  word_t snap;

  task automatic chk(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expand one accepted beat into the words the downstream side must see.
  task automatic push_model(input beat_t b);
    int    hi_byte;
    int    nw;
    word_t w;
    hi_byte = -1;
    for (int i = 0; i < KB; i++) if (b.keep[i]) hi_byte = i;
    if (!b.last)         nw = R;
    else if (hi_byte < 0) nw = 1;
    else                  nw = hi_byte / BPW + 1;
    for (int k = 0; k < nw; k++) begin
      w.data = b.data[k*OUT_W +: OUT_W];
      w.keep = b.keep[k*BPW +: BPW];
      w.last = b.last && (k == nw - 1);
      expq.push_back(w);
    end
    if ((!b.last && b.keep != '1) || (b.last && b.keep == '0)) begin
      if (exp_err < 65535) exp_err++;
    end
  endtask

  function automatic logic [15:0] exp_err_count();
`ifdef ETH_DOWNSIZE_ERR_CNT_EN
    return 16'(exp_err);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [KB-1:0] keep_bytes(input int n);
    logic [KB-1:0] k;
    k = '0;
    for (int i = 0; i < KB; i++) if (i < n) k[i] = 1'b1;
    return k;
  endfunction

  task automatic add_beat(input logic last, input logic [KB-1:0] keep);
    beat_t b;
    for (int w = 0; w < IN_W / 32; w++) b.data[w*32 +: 32] = $urandom();
    b.keep = keep;
    b.last = last;
    src.push_back(b);
  endtask

  task automatic add_pkt(input int nbeats, input int last_bytes);
    for (int i = 0; i < nbeats - 1; i++) add_beat(1'b0, '1);
    add_beat(1'b1, keep_bytes(last_bytes));
  endtask

  // One clock: drive at the falling edge, then check what the next rising edge will move.
  task automatic cycle();
    @(negedge clk);
    o_tready = ($urandom_range(99) < ready_pct);
    if (src.size() > 0 && $urandom_range(99) < valid_pct) begin
      i_tvalid = 1'b1;
      i_tdata  = src[0].data;
      i_tkeep  = src[0].keep;
      i_tlast  = src[0].last;
    end else begin
      i_tvalid = 1'b0;
      i_tdata  = '0;
      i_tkeep  = '0;
      i_tlast  = 1'b0;
    end
    #1;
    if (stalled) begin
      chk("stall_valid", o_tvalid, 1'b1);
      chk("stall_data", o_tdata, snap.data);
      chk("stall_keep", o_tkeep, snap.keep);
      chk("stall_last", o_tlast, snap.last);
    end
    chk("o_tvalid", o_tvalid, expq.size() != 0);
    chk("i_tready", i_tready, (expq.size() == 0) || (o_tready && expq.size() == 1));
    chk("err_count", err_count, exp_err_count());
    stalled = 1'b0;
    if (o_tvalid && o_tready && expq.size() > 0) begin
      word_t e;
      e = expq.pop_front();
      chk("o_tdata", o_tdata, e.data);
      chk("o_tkeep", o_tkeep, e.keep);
      chk("o_tlast", o_tlast, e.last);
      words_out++;
    end else if (o_tvalid && !o_tready) begin
      stalled   = 1'b1;
      snap.data = o_tdata;
      snap.keep = o_tkeep;
      snap.last = o_tlast;
    end
    if (i_tvalid && i_tready) begin
      push_model(src[0]);
      void'(src.pop_front());
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((src.size() > 0 || expq.size() > 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    chk("drain_timeout", (src.size() > 0 || expq.size() > 0), 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_o_tvalid"}, o_tvalid, 1'b0);
    chk({tag, "_o_tlast"}, o_tlast, 1'b0);
    chk({tag, "_o_tkeep"}, o_tkeep, '0);
    chk({tag, "_o_tdata"}, o_tdata, '0);
    chk({tag, "_i_tready"}, i_tready, 1'b1);
    chk({tag, "_err_count"}, err_count, '0);
  endtask

  initial begin
    beat_t b;
    int    n;

    // Step 1: reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Step 2: one full tlast beat with bytes 0x00..0x3F.
    for (int i = 0; i < KB; i++) b.data[i*8 +: 8] = 8'(i);
    b.keep = '1;
    b.last = 1'b1;
    src.push_back(b);
    ready_pct = 100; valid_pct = 100;
    cycle();
    cycle();
    chk("word0_const", o_tdata, 64'h0706050403020100);
    drain(100);

    // Step 3: two-beat packet ending with 12 bytes.
    add_pkt(2, 12);
    drain(100);

    // Step 4: back-to-back packets with no backpressure.
    for (int p = 0; p < 5; p++) add_pkt($urandom_range(1, 3), $urandom_range(1, 64));
    drain(300);

    // Step 5: random backpressure and input gaps.
    ready_pct = 50; valid_pct = 70;
    for (int p = 0; p < 20; p++) add_pkt($urandom_range(1, 3), $urandom_range(0, 64));
    drain(3000);

    // Step 6: zero-keep tlast beat, then a half-filled non-last beat.
    ready_pct = 100; valid_pct = 100;
    add_beat(1'b1, '0);
    drain(50);
    add_beat(1'b0, keep_bytes(32));
    add_beat(1'b1, keep_bytes(20));
    drain(100);

    // Step 7: reset after three words of a full beat have left.
    add_pkt(1, 64);
    words_out = 0;
    n = 0;
    while (words_out < 3 && n < 50) begin
      cycle();
      n++;
    end
    chk("pre_reset_words", words_out, 3);
    @(negedge clk);
    rst_n    = 1'b0;
    i_tvalid = 1'b0;
    @(negedge clk);
    #1;
    check_reset_values("midreset");
    rst_n = 1'b1;
    expq.delete();
    src.delete();
    exp_err = 0;
    stalled = 1'b0;
    add_pkt(2, 40);
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
